// File: rtl/gf2m_pkg.sv
// Shared GF(2^m) definitions: default field, inverter FSM encoding and a
// polynomial-basis squarer usable by any block working in the same field.
package gf2m_pkg;

    // Default field: x^233 + x^74 + 1
    localparam int GF2M_M_DEFAULT = 233;
    localparam logic [233:0] GF2M_POLY_DEFAULT = (234'd1 << 233) | (234'd1 << 74) | 234'd1;

    // Widest field the squarer helper supports; callers zero-extend into it.
    localparam int GF2M_MAX_M = 571;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SQR,
        ST_MUL,
        ST_FSQ,
        ST_ZBYP,
        ST_DONE
    } state_t;

    // Square x modulo poly in a field of degree m. Bits i of x move to 2i,
    // then the 2m-1 bit result is folded down from the top bit.
    function automatic logic [GF2M_MAX_M-1:0] gf2m_square(
        input logic [GF2M_MAX_M-1:0] x,
        input logic [GF2M_MAX_M:0]   poly,
        input int                    m
    );
        logic [2*GF2M_MAX_M-2:0] t;
        t = '0;
        for (int i = 0; i < GF2M_MAX_M; i++) begin
            if (i < m) begin
                t[2*i] = x[i];
            end
        end
        for (int j = 2*GF2M_MAX_M-2; j >= 0; j--) begin
            if (j >= m && j <= 2*m-2 && t[j]) begin
                t[j-m +: GF2M_MAX_M+1] = t[j-m +: GF2M_MAX_M+1] ^ poly;
            end
        end
        return t[GF2M_MAX_M-1:0];
    endfunction

endpackage

// File: rtl/gf2m_fermat_inv_mult.sv
// MSB-first digit-serial GF(2^M) multiplier, D bits of B per cycle with
// interleaved reduction. START loads the operands; DONE pulses during the
// K-th following cycle with P (combinational) holding the fully reduced product.
module gf2m_digit_mult
    import gf2m_pkg::*;
#(
    parameter int         M    = GF2M_M_DEFAULT,
    parameter logic [M:0] POLY = GF2M_POLY_DEFAULT,
    parameter int         D    = 1
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         START,
    input  logic [M-1:0] A,
    input  logic [M-1:0] B,
    output logic         DONE,
    output logic [M-1:0] P
);

    localparam int K  = (M + D - 1) / D;
    localparam int KD = K * D;
    localparam int CW = $clog2(K + 1);

    // Multiply by x and reduce once.
    function automatic logic [M-1:0] mulx(input logic [M-1:0] v);
        return {v[M-2:0], 1'b0} ^ (v[M-1] ? POLY[M-1:0] : '0);
    endfunction

    logic [M-1:0]  a_reg;
    logic [KD-1:0] b_reg;
    logic [M-1:0]  acc_reg;
    logic [CW-1:0] cnt_reg;
    logic          busy_reg;
    logic [D-1:0]  digit;
    logic [M-1:0]  acc_next;

    // B is zero-extended on top, so the first digit carries the padding.
    assign digit = b_reg[KD-1 -: D];

    // Per digit bit: A*x^gi, the accumulator shifted gi+1 times, and the
    // running sum of the selected A multiples.
    for (genvar gi = 0; gi < D; gi++) begin : g_stage
        logic [M-1:0] ap;
        logic [M-1:0] acc;
        logic [M-1:0] part;
        if (gi == 0) begin : g_first
            assign ap   = a_reg;
            assign acc  = mulx(acc_reg);
            assign part = digit[0] ? ap : '0;
        end else begin : g_next
            assign ap   = mulx(g_stage[gi-1].ap);
            assign acc  = mulx(g_stage[gi-1].acc);
            assign part = g_stage[gi-1].part ^ (digit[gi] ? ap : '0);
        end
    end

    // Horner step: acc * x^D + A * digit
    assign acc_next = g_stage[D-1].acc ^ g_stage[D-1].part;
    assign P        = acc_next;
    assign DONE     = busy_reg && (cnt_reg == CW'(1));

    // Operand load on START, then one digit per cycle for K cycles.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_reg    <= '0;
            b_reg    <= '0;
            acc_reg  <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
        end else if (START) begin
            a_reg    <= A;
            b_reg    <= KD'(B);
            acc_reg  <= '0;
            cnt_reg  <= CW'(K);
            busy_reg <= 1'b1;
        end else if (busy_reg) begin
            acc_reg  <= acc_next;
            b_reg    <= b_reg << D;
            cnt_reg  <= cnt_reg - CW'(1);
            busy_reg <= (cnt_reg != CW'(1));
        end
    end

endmodule

// File: rtl/gf2m_fermat_inv.sv
// GF(2^M) inverter, A^-1 = A^(2^M-2) by left-to-right square-and-multiply.
// Each of the M-2 iterations squares X (1 cycle) then multiplies by A
// (K cycles); a final squaring produces the result. Zero input bypasses.
module gf2m_fermat_inv
    import gf2m_pkg::*;
#(
    parameter int         M    = GF2M_M_DEFAULT,
    parameter logic [M:0] POLY = GF2M_POLY_DEFAULT,
    parameter int         D    = 1
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [M-1:0] DIN,
    input  logic         IN_VALID,
    output logic         IN_READY,
    output logic [M-1:0] DOUT,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic         ZERO_ERR
);

    localparam int CW = $clog2(M);

    state_t       state_reg, state_next;
    logic [M-1:0] a_reg, x_reg, dout_reg;
    logic [CW-1:0] cnt_reg;
    logic         out_valid_reg, zero_err_reg;
    logic         mult_start, mult_done;
    logic [M-1:0] mult_p, sq_x;

    logic [GF2M_MAX_M-1:0] x_wide, sq_wide;
    logic [GF2M_MAX_M:0]   poly_wide;

    // Widen X and POLY to the helper's fixed width.
    always_comb begin
        x_wide              = '0;
        x_wide[M-1:0]       = x_reg;
        poly_wide           = '0;
        poly_wide[M:0]      = POLY;
    end

    assign sq_wide = gf2m_square(x_wide, poly_wide, M);
    assign sq_x    = sq_wide[M-1:0];

    if (M < GF2M_MAX_M) begin : g_sq_pad
        logic sq_unused;
        assign sq_unused = |sq_wide[GF2M_MAX_M-1:M];
    end

    // The multiplier loads on the SQR->MUL edge with the freshly squared X.
    gf2m_digit_mult #(.M(M), .POLY(POLY), .D(D)) u_mult (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (mult_start),
        .A     (sq_x),
        .B     (a_reg),
        .DONE  (mult_done),
        .P     (mult_p)
    );

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (IN_VALID) state_next = (DIN == '0) ? ST_ZBYP : ST_SQR;
            ST_SQR:  state_next = ST_MUL;
            ST_MUL:  if (mult_done) state_next = (cnt_reg == CW'(1)) ? ST_FSQ : ST_SQR;
            ST_FSQ:  state_next = ST_DONE;
            ST_ZBYP: state_next = ST_DONE;
            ST_DONE: if (OUT_READY) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        IN_READY   = (state_reg == ST_IDLE);
        mult_start = (state_reg == ST_SQR);
    end

    // Datapath: operand capture, X update, iteration count and result registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_reg         <= '0;
            x_reg         <= '0;
            cnt_reg       <= '0;
            dout_reg      <= '0;
            out_valid_reg <= 1'b0;
            zero_err_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: if (IN_VALID) begin
                    a_reg   <= DIN;
                    x_reg   <= DIN;
                    cnt_reg <= CW'(M - 2);
                end
                ST_SQR:  x_reg <= sq_x;
                ST_MUL:  if (mult_done) begin
                    x_reg   <= mult_p;
                    cnt_reg <= cnt_reg - CW'(1);
                end
                ST_FSQ: begin
                    dout_reg      <= sq_x;
                    zero_err_reg  <= 1'b0;
                    out_valid_reg <= 1'b1;
                end
                ST_ZBYP: begin
                    dout_reg      <= '0;
                    zero_err_reg  <= 1'b1;
                    out_valid_reg <= 1'b1;
                end
                ST_DONE: if (OUT_READY) out_valid_reg <= 1'b0;
                default: ;
            endcase
        end
    end

    assign DOUT      = dout_reg;
    assign OUT_VALID = out_valid_reg;
    assign ZERO_ERR  = zero_err_reg;

endmodule

// File: tb/tb_gf2m_fermat_inv.sv
// Scoreboard bench: three inverter instances (GF(2^8) with D=4 and D=1,
// GF(2^233) with D=32). Stimulus pushes expectations, monitors pop on handshake.
module tb_gf2m_fermat_inv;

    localparam logic [8:0]   P8     = 9'h11B;
    localparam logic [232:0] TAP233 = (233'd1 << 74) | 233'd1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp;
        bit         zero;
        int         acc;
        int         lat;
    } exp8_t;

    typedef struct {
        logic [232:0] din;
        int           acc;
    } exp233_t;

    exp8_t   qa[$];
    exp8_t   qb[$];
    exp233_t qc[$];

    logic [7:0]   din_a, dout_a, din_b, dout_b;
    logic         iv_a, ir_a, ov_a, or_a, ze_a;
    logic         iv_b, ir_b, ov_b, or_b, ze_b;
    logic [232:0] din_c, dout_c;
    logic         iv_c, ir_c, ov_c, or_c, ze_c;

    gf2m_fermat_inv #(.M(8), .POLY(P8), .D(4)) dut_a (
        .CLK(clk), .RST_N(rst_n), .DIN(din_a), .IN_VALID(iv_a), .IN_READY(ir_a),
        .DOUT(dout_a), .OUT_VALID(ov_a), .OUT_READY(or_a), .ZERO_ERR(ze_a));

    gf2m_fermat_inv #(.M(8), .POLY(P8), .D(1)) dut_b (
        .CLK(clk), .RST_N(rst_n), .DIN(din_b), .IN_VALID(iv_b), .IN_READY(ir_b),
        .DOUT(dout_b), .OUT_VALID(ov_b), .OUT_READY(or_b), .ZERO_ERR(ze_b));

    gf2m_fermat_inv #(.D(32)) dut_c (
        .CLK(clk), .RST_N(rst_n), .DIN(din_c), .IN_VALID(iv_c), .IN_READY(ir_c),
        .DOUT(dout_c), .OUT_VALID(ov_c), .OUT_READY(or_c), .ZERO_ERR(ze_c));

    // ---------------- reference arithmetic ----------------
    function automatic logic [7:0] gf8_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] t;
        r = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1B : 8'h00);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv8_ref(input logic [7:0] a);
        for (int v = 1; v < 256; v++) begin
            if (gf8_mul(a, 8'(v)) == 8'h01) return 8'(v);
        end
        return 8'h00;
    endfunction

    function automatic logic [232:0] gf233_mul(input logic [232:0] a, input logic [232:0] b);
        logic [232:0] r;
        logic [232:0] t;
        r = '0;
        t = a;
        for (int i = 0; i < 233; i++) begin
            if (b[i]) r = r ^ t;
            t = {t[231:0], 1'b0} ^ (t[232] ? TAP233 : '0);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- monitors ----------------
    logic       pv_a = 1'b0, pv_b = 1'b0, pv_c = 1'b0;
    logic [7:0] held_a, held_b;

    always @(negedge clk) begin
        if (!rst_n) begin
            pv_a = 1'b0;
        end else begin
            if (ov_a && !pv_a) begin
                check("a_out_expected", 256'(qa.size() != 0), 1);
                if (qa.size() != 0) check("a_latency", cyc - qa[0].acc, qa[0].lat);
                held_a = dout_a;
            end
            if (ov_a) begin
                check("a_dout_stable", dout_a, held_a);
                check("a_in_ready_busy", ir_a, 0);
                if (or_a && qa.size() != 0) begin
                    check("a_dout", dout_a, qa[0].exp);
                    check("a_zero_err", ze_a, qa[0].zero);
                    $display("tb a: din=%h dout=%h zero_err=%b", qa[0].din, dout_a, ze_a);
                    void'(qa.pop_front());
                end
            end
            pv_a = ov_a;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            pv_b = 1'b0;
        end else begin
            if (ov_b && !pv_b) begin
                check("b_out_expected", 256'(qb.size() != 0), 1);
                if (qb.size() != 0) check("b_latency", cyc - qb[0].acc, qb[0].lat);
                held_b = dout_b;
            end
            if (ov_b) begin
                check("b_dout_stable", dout_b, held_b);
                if (or_b && qb.size() != 0) begin
                    check("b_dout", dout_b, qb[0].exp);
                    check("b_zero_err", ze_b, qb[0].zero);
                    $display("tb b: din=%h dout=%h zero_err=%b", qb[0].din, dout_b, ze_b);
                    void'(qb.pop_front());
                end
            end
            pv_b = ov_b;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            pv_c = 1'b0;
        end else begin
            if (ov_c && !pv_c) begin
                check("c_out_expected", 256'(qc.size() != 0), 1);
                if (qc.size() != 0) check("c_latency", cyc - qc[0].acc, 2080);
            end
            if (ov_c && or_c && qc.size() != 0) begin
                check("c_product_is_one", gf233_mul(qc[0].din, dout_c), 1);
                check("c_zero_err", ze_c, 0);
                $display("tb c: din=%h dout=%h", qc[0].din, dout_c);
                void'(qc.pop_front());
            end
            pv_c = ov_c;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_a(input logic [7:0] d, input logic [7:0] e, input bit z, input int lat);
        int n = 0;
        @(negedge clk);
        while (!ir_a && n < 200) begin @(negedge clk); n++; end
        check("a_accept_ready", ir_a, 1);
        din_a = d;
        iv_a  = 1'b1;
        qa.push_back(exp8_t'{d, e, z, cyc + 1, lat});
        @(negedge clk);
        iv_a  = 1'b0;
        din_a = 8'hA5;
    endtask

    task automatic drain_a(input int budget);
        int n = 0;
        while (qa.size() != 0 && n < budget) begin @(negedge clk); n++; end
        check("a_drain", qa.size(), 0);
        qa.delete();
    endtask

    task automatic send_b(input logic [7:0] d, input logic [7:0] e, input int lat);
        int n = 0;
        @(negedge clk);
        while (!ir_b && n < 200) begin @(negedge clk); n++; end
        check("b_accept_ready", ir_b, 1);
        din_b = d;
        iv_b  = 1'b1;
        qb.push_back(exp8_t'{d, e, 1'b0, cyc + 1, lat});
        @(negedge clk);
        iv_b  = 1'b0;
    endtask

    task automatic drain_b(input int budget);
        int n = 0;
        while (qb.size() != 0 && n < budget) begin @(negedge clk); n++; end
        check("b_drain", qb.size(), 0);
        qb.delete();
    endtask

    task automatic run_c(input logic [232:0] d);
        int n = 0;
        @(negedge clk);
        while (!ir_c && n < 200) begin @(negedge clk); n++; end
        check("c_accept_ready", ir_c, 1);
        din_c = d;
        iv_c  = 1'b1;
        qc.push_back(exp233_t'{d, cyc + 1});
        @(negedge clk);
        iv_c = 1'b0;
        n = 0;
        while (qc.size() != 0 && n < 3000) begin @(negedge clk); n++; end
        check("c_drain", qc.size(), 0);
        qc.delete();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        din_a = '0; iv_a = 1'b0; or_a = 1'b1;
        din_b = '0; iv_b = 1'b0; or_b = 1'b1;
        din_c = '0; iv_c = 1'b0; or_c = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_a_in_ready", ir_a, 1);
        check("rst_a_out_valid", ov_a, 0);
        check("rst_a_dout", dout_a, 0);
        check("rst_a_zero_err", ze_a, 0);
        check("rst_c_dout", dout_c, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_b_in_ready", ir_b, 1);
        check("post_rst_b_out_valid", ov_b, 0);

        // D=1: known AES-field inverse, 55-edge latency
        send_b(8'h53, 8'hCA, 55);
        drain_b(200);

        // D=4: directed vectors, zero bypass, unity
        send_a(8'h02, 8'h8D, 1'b0, 19);
        send_a(8'h00, 8'h00, 1'b1, 1);
        send_a(8'h01, 8'h01, 1'b0, 19);
        send_a(8'h53, 8'hCA, 1'b0, 19);
        drain_a(100);

        // Hold OUT_READY low for 20 cycles; a busy-time operand must be ignored
        @(posedge clk); #1 or_a = 1'b0;
        send_a(8'h53, 8'hCA, 1'b0, 19);
        repeat (3) @(negedge clk);
        din_a = 8'h02;
        iv_a  = 1'b1;
        @(negedge clk);
        iv_a  = 1'b0;
        n = 0;
        while (!ov_a && n < 100) begin @(negedge clk); n++; end
        check("a_hold_valid_seen", ov_a, 1);
        repeat (20) @(negedge clk);
        check("a_hold_still_valid", ov_a, 1);
        @(posedge clk); #1 or_a = 1'b1;
        drain_a(10);
        repeat (30) @(negedge clk);
        check("a_no_extra_output", ov_a, 0);

        // Asynchronous reset in the middle of a multiply
        send_a(8'h53, 8'hCA, 1'b0, 19);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_a_out_valid", ov_a, 0);
        check("arst_a_dout", dout_a, 0);
        check("arst_a_zero_err", ze_a, 0);
        qa.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_a_in_ready", ir_a, 1);
        send_a(8'h53, 8'hCA, 1'b0, 19);
        drain_a(100);

        // Sweep every nonzero element against a brute-force inverse
        for (int v = 1; v < 256; v++) begin
            send_a(8'(v), inv8_ref(8'(v)), 1'b0, 19);
            drain_a(100);
        end

        // Default 233-bit field with D=32
        run_c(233'h1);
        run_c(233'h0_1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321_1357_9BDF_2468_ACE0_5555_AAAA);
        run_c(233'h1_8000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0003);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
